// File: rtl/burst_mem_responder.sv
// burst_mem_responder: line-granular burst memory responder.
// Accepts a read or write of one 256-bit line and moves it as BEATS
// consecutive 32-bit beats after LATENCY cycles. Storage is not cleared
// by reset.
//
// Handshake: mem_read/mem_write are levels held by the requester and are
// sampled only in IDLE. Once accepted, the op, line and byte enables are
// frozen until the next IDLE. mem_resp is a beat strobe with no back-pressure.
// For a read, mem_rdata is valid in each resp cycle. For a write, mem_wdata is
// captured at the edge that ends each resp cycle; the requester moves to the
// next beat after seeing resp. DONE lasts one cycle and ignores requests, so
// a request that is still held restarts only from IDLE.
module burst_mem_responder #(
  parameter int DEPTH_LINES = 64,
  parameter int LATENCY     = 4,
  parameter int BEATS       = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [31:0] mem_address,
  input  logic [31:0] mem_byte_enable,
  input  logic [31:0] mem_wdata,
  output logic [31:0] mem_rdata,
  output logic        mem_resp,
  output logic        busy
);

  localparam int IW = $clog2(DEPTH_LINES);
  localparam int BW = $clog2(BEATS);
  localparam int LW = $clog2(LATENCY) + 1;
  // WAIT lasts LATENCY-1 cycles; the counter runs from 0 to LATENCY-2.
  localparam logic [LW-1:0] LAT_LAST  = LW'((LATENCY > 1) ? (LATENCY - 2) : 0);
  localparam logic [BW-1:0] BEAT_LAST = BW'(BEATS - 1);

  typedef enum logic [1:0] {IDLE, WAIT, BURST, DONE} state_t;

  state_t          state, next_state;
  logic            op_read_q;
  logic [IW-1:0]   line_q;
  logic [31:0]     be_q;
  logic [LW-1:0]   lat_q;
  logic [BW-1:0]   beat_q;
  logic [31:0]     store [DEPTH_LINES*BEATS];

  logic            req;
  logic [IW-1:0]   addr_line;
  logic [IW-1:0]   rd_line;
  logic [BW-1:0]   rd_beat;
  logic            rd_op;
  logic [31:0]     rdata_d;
  logic [3:0]      be_beat;
  logic [31:0]     wr_word;

  assign req       = mem_read | mem_write;
  assign addr_line = mem_address[5 +: IW];
  assign mem_resp  = (state == BURST);
  assign busy      = (state != IDLE);
  assign be_beat   = be_q[{beat_q, 2'b00} +: 4];

  // Next-state logic for the request / wait / burst / done sequence.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (req) next_state = (LATENCY == 1) ? BURST : WAIT;
      WAIT:    if (lat_q == LAT_LAST) next_state = BURST;
      BURST:   if (beat_q == BEAT_LAST) next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Select the word presented in the next cycle; reads in IDLE use the live
  // request so that LATENCY==1 can enter BURST directly.
  always_comb begin
    rd_line = line_q;
    rd_op   = op_read_q;
    rd_beat = '0;
    if (state == IDLE) begin
      rd_line = addr_line;
      rd_op   = mem_read;
    end
    if (state == BURST) rd_beat = beat_q + 1'b1;
    rdata_d = '0;
    if ((next_state == BURST) && rd_op) rdata_d = store[{rd_line, rd_beat}];
  end

  // Merge the current write beat into the addressed word under its byte mask.
  always_comb begin
    wr_word = store[{line_q, beat_q}];
    for (int b = 0; b < 4; b++) begin
      if (be_beat[b]) wr_word[8*b +: 8] = mem_wdata[8*b +: 8];
    end
  end

  // State register, counters and registered read data.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      lat_q     <= '0;
      beat_q    <= '0;
      mem_rdata <= '0;
    end else begin
      state     <= next_state;
      mem_rdata <= rdata_d;
      if ((state == WAIT) && (lat_q != LAT_LAST)) lat_q <= lat_q + 1'b1;
      else                                         lat_q <= '0;
      if ((state == BURST) && (beat_q != BEAT_LAST)) beat_q <= beat_q + 1'b1;
      else                                            beat_q <= '0;
    end
  end

  // Capture the accepted request; frozen until the next IDLE.
  always_ff @(posedge clk) begin
    if ((state == IDLE) && req) begin
      op_read_q <= mem_read;
      line_q    <= addr_line;
      be_q      <= mem_byte_enable;
    end
  end

  // Storage write; a beat in flight at a reset edge still commits.
  always_ff @(posedge clk) begin
    if ((state == BURST) && !op_read_q) store[{line_q, beat_q}] <= wr_word;
  end

endmodule

// File: tb/tb_burst_mem_responder.sv
// Testbench for burst_mem_responder: table of line transactions on a
// LATENCY=4 instance, hand sequences for reset mid-write, and back-to-back
// reads on a LATENCY=1 instance.
module tb_burst_mem_responder;

  localparam int LAT = 4;

  logic        clk;
  logic        rst_n;
  logic        mem_read, mem_write;
  logic [31:0] mem_address, mem_byte_enable, mem_wdata, mem_rdata;
  logic        mem_resp, busy;

  logic        r1_read, r1_write;
  logic [31:0] r1_address, r1_byte_enable, r1_wdata, r1_rdata;
  logic        r1_resp, r1_busy;

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_q[$];

  typedef struct {
    logic             rd;
    logic             wr;
    logic [31:0]      addr;
    logic [31:0]      be;
    logic [7:0][31:0] wd;
    logic [7:0][31:0] exp;
  } vec_t;

  vec_t vecs[12];

  burst_mem_responder #(.DEPTH_LINES(64), .LATENCY(LAT), .BEATS(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .mem_read(mem_read), .mem_write(mem_write),
    .mem_address(mem_address), .mem_byte_enable(mem_byte_enable),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_resp(mem_resp),
    .busy(busy)
  );

  burst_mem_responder #(.DEPTH_LINES(64), .LATENCY(1), .BEATS(8)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .mem_read(r1_read), .mem_write(r1_write),
    .mem_address(r1_address), .mem_byte_enable(r1_byte_enable),
    .mem_wdata(r1_wdata), .mem_rdata(r1_rdata), .mem_resp(r1_resp),
    .busy(r1_busy)
  );

  // Clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop if something hangs.
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic logic [7:0][31:0] seq(input logic [31:0] base);
    logic [7:0][31:0] r;
    for (int k = 0; k < 8; k++) r[k] = base + 32'(k);
    return r;
  endfunction

  function automatic logic [7:0][31:0] rep(input logic [31:0] v);
    logic [7:0][31:0] r;
    for (int k = 0; k < 8; k++) r[k] = v;
    return r;
  endfunction

  // Driver: run one transaction starting just after a rising edge.
  // Cycle 0 presents the request; beat k resp is expected in cycle LAT+k.
  task automatic run_txn(input vec_t v, input string name);
    int beat;
    int cyc;
    logic [31:0] e;
    if (v.rd) for (int k = 0; k < 8; k++) exp_q.push_back(v.exp[k]);
    mem_read        = v.rd;
    mem_write       = v.wr;
    mem_address     = v.addr;
    mem_byte_enable = v.be;
    mem_wdata       = v.wd[0];
    beat = 0;
    cyc  = 0;
    while (beat < 8 && cyc < 64) begin
      @(negedge clk);
      if (cyc == 0) check({name, " idle_busy"}, 32'(busy), 32'd0);
      if (mem_resp) begin
        check({name, " resp_cycle"}, 32'(cyc), 32'(LAT + beat));
        if (v.rd) begin
          e = exp_q.pop_front();
          check($sformatf("%s rdata_beat%0d", name, beat), mem_rdata, e);
        end
        beat++;
      end else if (cyc > 0) begin
        check({name, " wait_busy"}, 32'(busy), 32'd1);
        check({name, " rdata_idle"}, mem_rdata, 32'd0);
      end
      @(posedge clk); #1;
      cyc++;
      if (beat < 8) mem_wdata = v.wd[beat];
      else begin
        mem_read  = 1'b0;
        mem_write = 1'b0;
      end
    end
    check({name, " beats_seen"}, 32'(beat), 32'd8);
    mem_read  = 1'b0;
    mem_write = 1'b0;
    exp_q.delete();
    // DONE cycle.
    @(negedge clk);
    check({name, " done_resp"}, 32'(mem_resp), 32'd0);
    check({name, " done_busy"}, 32'(busy), 32'd1);
    @(posedge clk); #1;
  endtask

  initial begin
    vec_t v;
    logic [7:0][31:0] wd;
    int beat;
    int cyc;
    logic exp_resp;
    logic exp_busy;

    // Transaction table.
    vecs[0]  = '{rd:1'b0, wr:1'b1, addr:32'h40,  be:32'hFFFF_FFFF, wd:seq(32'h1111_0000), exp:'0};
    vecs[1]  = '{rd:1'b1, wr:1'b0, addr:32'h40,  be:32'h0,         wd:'0, exp:seq(32'h1111_0000)};
    vecs[2]  = '{rd:1'b0, wr:1'b1, addr:32'h80,  be:32'hFFFF_FFFF, wd:rep(32'hAAAA_AAAA), exp:'0};
    vecs[3]  = '{rd:1'b0, wr:1'b1, addr:32'h80,  be:32'h0000_000F, wd:rep(32'hBBBB_BBBB), exp:'0};
    vecs[4]  = '{rd:1'b1, wr:1'b0, addr:32'h80,  be:32'h0,         wd:'0, exp:rep(32'hAAAA_AAAA)};
    vecs[4].exp[0] = 32'hBBBB_BBBB;
    vecs[5]  = '{rd:1'b1, wr:1'b1, addr:32'h40,  be:32'hFFFF_FFFF, wd:rep(32'hFFFF_FFFF), exp:seq(32'h1111_0000)};
    vecs[6]  = '{rd:1'b1, wr:1'b0, addr:32'h40,  be:32'h0,         wd:'0, exp:seq(32'h1111_0000)};
    vecs[7]  = '{rd:1'b0, wr:1'b1, addr:32'h40,  be:32'h00F0_0C00, wd:rep(32'h7777_7777), exp:'0};
    vecs[8]  = '{rd:1'b1, wr:1'b0, addr:32'h40,  be:32'h0,         wd:'0, exp:seq(32'h1111_0000)};
    vecs[8].exp[2] = 32'h7777_0002;
    vecs[8].exp[5] = 32'h7777_7777;
    vecs[9]  = '{rd:1'b0, wr:1'b1, addr:32'h81F, be:32'hFFFF_FFFF, wd:rep(32'hDEAD_BEEF), exp:'0};
    vecs[10] = '{rd:1'b1, wr:1'b0, addr:32'h0,   be:32'h0,         wd:'0, exp:rep(32'hDEAD_BEEF)};
    vecs[11] = '{rd:1'b0, wr:1'b1, addr:32'hC0,  be:32'hFFFF_FFFF, wd:seq(32'h5555_0000), exp:'0};

    // Reset block.
    rst_n = 1'b0;
    mem_read = 1'b0; mem_write = 1'b0; mem_address = '0;
    mem_byte_enable = '0; mem_wdata = '0;
    r1_read = 1'b0; r1_write = 1'b0; r1_address = '0;
    r1_byte_enable = '0; r1_wdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset resp", 32'(mem_resp), 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    check("reset rdata", mem_rdata, 32'd0);
    check("reset1 busy", 32'(r1_busy), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Table-driven transactions.
    for (int i = 0; i < 12; i++) run_txn(vecs[i], $sformatf("vec%0d", i));

    // Reset on the edge that ends beat 3 of a write to line 0xC0.
    wd = seq(32'hC0DE_0000);
    mem_write = 1'b1; mem_read = 1'b0; mem_address = 32'hC0;
    mem_byte_enable = 32'hFFFF_FFFF; mem_wdata = wd[0];
    beat = 0;
    cyc  = 0;
    while (beat < 4 && cyc < 64) begin
      @(negedge clk);
      if (mem_resp) begin
        beat++;
        if (beat == 4) rst_n = 1'b0;
      end
      @(posedge clk); #1;
      cyc++;
      if (beat < 4) mem_wdata = wd[beat];
    end
    check("rstmid beats_seen", 32'(beat), 32'd4);
    mem_write = 1'b0;
    @(negedge clk);
    check("rstmid resp", 32'(mem_resp), 32'd0);
    check("rstmid busy", 32'(busy), 32'd0);
    check("rstmid rdata", mem_rdata, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    v = '{rd:1'b1, wr:1'b0, addr:32'hC0, be:32'h0, wd:'0, exp:seq(32'h5555_0000)};
    for (int k = 0; k < 4; k++) v.exp[k] = 32'hC0DE_0000 + 32'(k);
    run_txn(v, "rstmid_rb");

    // Back-to-back reads with the request held, LATENCY=1.
    r1_read = 1'b1;
    r1_address = 32'h0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      exp_resp = ((c >= 1) && (c <= 8)) || ((c >= 11) && (c <= 18));
      exp_busy = (c != 0) && (c != 10);
      check($sformatf("lat1 resp_c%0d", c), 32'(r1_resp), 32'(exp_resp));
      check($sformatf("lat1 busy_c%0d", c), 32'(r1_busy), 32'(exp_busy));
      if (!exp_resp) check($sformatf("lat1 rdata_c%0d", c), r1_rdata, 32'd0);
      @(posedge clk); #1;
      if (c == 18) r1_read = 1'b0;
    end
    @(negedge clk);
    check("lat1 final_busy", 32'(r1_busy), 32'd0);

    // Report.
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
